// File: rtl/irq_ctrl_pkg.sv
// Shared encodings and vector addresses for the interrupt/exception controller.
// Optional UART interrupt source is enabled by defining UART_IRQ_EN.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_USER   = 2'd0,
        ST_KERNEL = 2'd1,
        ST_SHADOW = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_TIMER = 2'd1,
        CAUSE_UART  = 2'd2,
        CAUSE_EXC   = 2'd3
    } cause_t;

    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
    localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

    // Bit positions of the request/grant vectors, highest priority at the top.
    localparam int unsigned REQ_UART  = 0;
    localparam int unsigned REQ_TIMER = 1;
    localparam int unsigned REQ_EXC   = 2;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority selector: exception over timer over uart, one-hot grant plus cause code.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] grant,
    output cause_t     cause
);

    always_comb begin
        grant = '0;
        cause = CAUSE_NONE;
        if (req[REQ_EXC]) begin
            grant[REQ_EXC] = 1'b1;
            cause          = CAUSE_EXC;
        end else if (req[REQ_TIMER]) begin
            grant[REQ_TIMER] = 1'b1;
            cause            = CAUSE_TIMER;
        end else if (req[REQ_UART]) begin
            grant[REQ_UART] = 1'b1;
            cause           = CAUSE_UART;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/exception controller with USER/KERNEL/SHADOW modes and same-cycle redirect.
// Define UART_IRQ_EN to latch and arbitrate the UART receive-done pulse.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        timer_irq,
    input  logic        uart_irq,
    input  logic        illegal_op,
    input  logic        eret,
    output logic        irq_take,
    output logic        exc_take,
    output logic [31:0] vector,
    output logic        epc_we,
    output logic [31:0] epc,
    output logic [1:0]  cause,
    output logic        in_kernel
);

    state_t     state;
    state_t     state_nxt;
    cause_t     cause_q;
    cause_t     sel_cause;
    logic [2:0] req;
    logic [2:0] grant;
    logic       allow_irq;
    logic       uart_req;

`ifdef UART_IRQ_EN
    logic uart_pend;

    // A new pulse in the same cycle as the take keeps the request pending.
    always_ff @(posedge clk) begin
        if (!reset_n) uart_pend <= 1'b0;
        else          uart_pend <= uart_irq | (uart_pend & ~grant[REQ_UART]);
    end

    assign uart_req = uart_pend;
`else
    logic unused_uart;
    assign unused_uart = uart_irq ^ grant[REQ_UART];
    assign uart_req    = 1'b0;
`endif

    // Kernel-space code (pc[31]) is never interrupted; requests simply wait.
    assign allow_irq = (state == ST_USER) && !pc[31];
    assign req       = {illegal_op, timer_irq & allow_irq, uart_req & allow_irq};

    irq_prio_enc u_prio (
        .req   (req),
        .grant (grant),
        .cause (sel_cause)
    );

    always_comb begin
        irq_take  = 1'b0;
        exc_take  = 1'b0;
        vector    = '0;
        epc_we    = 1'b0;
        epc       = '0;
        state_nxt = state;
        if (reset_n) begin
            exc_take = grant[REQ_EXC];
            irq_take = grant[REQ_TIMER] | grant[REQ_UART];
            if (exc_take)      vector = EXC_VECTOR;
            else if (irq_take) vector = IRQ_VECTOR;
            case (state)
                ST_USER, ST_SHADOW: begin
                    if (exc_take) begin
                        epc_we    = 1'b1;
                        epc       = pc + 32'd4;
                        state_nxt = ST_KERNEL;
                    end else if (irq_take) begin
                        epc_we    = 1'b1;
                        epc       = pc;
                        state_nxt = ST_KERNEL;
                    end else if (state == ST_SHADOW) begin
                        state_nxt = ST_USER;
                    end
                end
                ST_KERNEL: begin
                    if (!illegal_op && eret) state_nxt = ST_SHADOW;
                end
                default: state_nxt = ST_USER;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_USER;
            cause_q <= CAUSE_NONE;
        end else begin
            state <= state_nxt;
            if (irq_take || exc_take) cause_q <= sel_cause;
        end
    end

    assign cause     = cause_q;
    assign in_kernel = reset_n && (state == ST_KERNEL);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: per-cycle expectations queued at drive time, popped at negedge.
module tb_irq_ctrl;

    localparam logic [31:0] IV = 32'h8000_0004;
    localparam logic [31:0] EV = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        timer_irq, uart_irq, illegal_op, eret;
    logic        irq_take, exc_take, epc_we, in_kernel;
    logic [31:0] vector, epc;
    logic [1:0]  cause;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    logic [1:0] c_last;

    typedef struct {
        logic        irq;
        logic        exc;
        logic [31:0] vec;
        logic        we;
        logic [31:0] epc;
        logic [1:0]  cause;
        logic        ink;
    } exp_t;

    exp_t sbq[$];

    irq_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc         (pc),
        .timer_irq  (timer_irq),
        .uart_irq   (uart_irq),
        .illegal_op (illegal_op),
        .eret       (eret),
        .irq_take   (irq_take),
        .exc_take   (exc_take),
        .vector     (vector),
        .epc_we     (epc_we),
        .epc        (epc),
        .cause      (cause),
        .in_kernel  (in_kernel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step %0d observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] p, input logic t, input logic u,
                        input logic il, input logic er, input logic ei, input logic ee,
                        input logic [31:0] ev, input logic ew, input logic [31:0] eepc,
                        input logic [1:0] ec, input logic ek);
        exp_t e;
        exp_t got;
        step_no++;
        reset_n    = rst;
        pc         = p;
        timer_irq  = t;
        uart_irq   = u;
        illegal_op = il;
        eret       = er;
        e.irq = ei; e.exc = ee; e.vec = ev; e.we = ew; e.epc = eepc; e.cause = ec; e.ink = ek;
        sbq.push_back(e);
        @(negedge clk);
        got = sbq.pop_front();
        chk("irq_take",  {31'd0, irq_take},  {31'd0, got.irq});
        chk("exc_take",  {31'd0, exc_take},  {31'd0, got.exc});
        chk("vector",    vector,             got.vec);
        chk("epc_we",    {31'd0, epc_we},    {31'd0, got.we});
        chk("epc",       epc,                got.epc);
        chk("cause",     {30'd0, cause},     {30'd0, got.cause});
        chk("in_kernel", {31'd0, in_kernel}, {31'd0, got.ink});
        @(posedge clk);
        #1;
    endtask

    // No redirect this cycle.
    task automatic nt(input logic rst, input logic [31:0] p, input logic t, input logic u,
                      input logic il, input logic er, input logic [1:0] c, input logic k);
        step(rst, p, t, u, il, er, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, c, k);
    endtask

    // Interrupt taken: epc is the squashed instruction.
    task automatic ti(input logic rst, input logic [31:0] p, input logic t, input logic u,
                      input logic il, input logic er, input logic [1:0] c, input logic k);
        step(rst, p, t, u, il, er, 1'b1, 1'b0, IV, 1'b1, p, c, k);
    endtask

    // Exception taken: epc is the following instruction when written.
    task automatic te(input logic rst, input logic [31:0] p, input logic t, input logic u,
                      input logic il, input logic er, input logic [1:0] c, input logic k,
                      input logic we);
        step(rst, p, t, u, il, er, 1'b0, 1'b1, EV, we, we ? p + 32'd4 : 32'd0, c, k);
    endtask

    initial begin
        reset_n = 1'b0; pc = '0; timer_irq = 1'b0; uart_irq = 1'b0; illegal_op = 1'b0; eret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nt(0, 32'h0000_006C, 1, 0, 1, 0, 2'd0, 0);
        ti(1, 32'h0000_006C, 1, 0, 0, 0, 2'd0, 0);
        nt(1, 32'h8000_0100, 1, 1, 0, 0, 2'd1, 1);
        te(1, 32'h8000_0104, 0, 0, 1, 0, 2'd1, 1, 1'b0);
        nt(1, 32'h8000_0108, 0, 0, 0, 1, 2'd3, 1);
        nt(1, 32'h0000_0100, 0, 0, 0, 0, 2'd3, 0);
`ifdef UART_IRQ_EN
        ti(1, 32'h0000_0100, 0, 0, 0, 0, 2'd3, 0);
        nt(1, 32'h8000_0000, 0, 0, 0, 1, 2'd2, 1);
        nt(1, 32'h0000_0100, 0, 1, 0, 0, 2'd2, 0);
        ti(1, 32'h0000_0104, 0, 1, 0, 0, 2'd2, 0);
        nt(1, 32'h8000_0000, 0, 0, 0, 1, 2'd2, 1);
        nt(1, 32'h0000_0104, 0, 0, 0, 0, 2'd2, 0);
        ti(1, 32'h0000_0108, 0, 0, 0, 0, 2'd2, 0);
        nt(1, 32'h8000_0000, 0, 0, 0, 1, 2'd2, 1);
        nt(1, 32'h0000_0108, 0, 0, 0, 0, 2'd2, 0);
        nt(1, 32'h0000_010C, 0, 0, 0, 0, 2'd2, 0);
        c_last = 2'd2;
`else
        nt(1, 32'h0000_0100, 0, 1, 0, 0, 2'd3, 0);
        nt(1, 32'h0000_0104, 0, 0, 0, 0, 2'd3, 0);
        c_last = 2'd3;
`endif
        te(1, 32'h0000_0040, 1, 0, 1, 0, c_last, 0, 1'b1);
        nt(1, 32'h8000_0000, 1, 0, 0, 1, 2'd3, 1);
        nt(1, 32'h0000_0044, 1, 0, 0, 0, 2'd3, 0);
        ti(1, 32'h0000_0044, 1, 0, 0, 0, 2'd3, 0);
        nt(1, 32'h8000_0000, 0, 0, 0, 1, 2'd1, 1);
        te(1, 32'h0000_0200, 0, 0, 1, 0, 2'd1, 0, 1'b1);
        nt(1, 32'h8000_0000, 0, 0, 0, 1, 2'd3, 1);
        nt(1, 32'h0000_0204, 0, 0, 0, 0, 2'd3, 0);
        nt(1, 32'h8000_0050, 1, 0, 0, 0, 2'd3, 0);
        ti(1, 32'h0000_0050, 1, 0, 0, 0, 2'd3, 0);
        nt(1, 32'h8000_0000, 0, 1, 0, 0, 2'd1, 1);
        nt(0, 32'h0000_0054, 1, 0, 1, 1, 2'd1, 0);
        nt(1, 32'h0000_0060, 0, 0, 0, 0, 2'd0, 0);
        nt(1, 32'h0000_0064, 0, 0, 0, 1, 2'd0, 0);
        nt(1, 32'h0000_0068, 0, 0, 0, 0, 2'd0, 0);
        te(1, 32'hFFFF_FFFC, 0, 0, 1, 0, 2'd0, 0, 1'b1);
        nt(1, 32'h8000_0000, 0, 0, 0, 0, 2'd3, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have port pc  input  32  PC of the instruction executing this cycle.
REQ-004 SHALL have port timer_irq  input  1  level request from timer (TCON-gated).
REQ-005 SHALL have port uart_irq  input  1  one-cycle pulse from UART receive-done.
REQ-006 SHALL have port illegal_op  input  1  decoder flags undefined opcode/funct this cycle.
REQ-007 SHALL have port eret  input  1  decoder flags jr $k0 this cycle.
REQ-008 SHALL have ports irq_take / exc_take  output  1 each  redirect this cycle to interrupt / error vector.
REQ-009 SHALL have port vector  output  32  0x80000004 on irq_take, 0x80000008 on exc_take, else 0.
REQ-010 SHALL have ports epc_we  output  1, epc  output  32  write enable and data for $k0.
REQ-011 SHALL have port cause  output  2  last taken source: 0 none, 1 timer, 2 uart, 3 exception.
REQ-012 SHALL have port in_kernel  output  1  current state is KERNEL.

Function
REQ-013 SHALL implement states USER, KERNEL, SHADOW; interrupts accepted only in USER.
REQ-014 SHALL latch uart_irq into uart_pend; clear it only on the cycle uart is taken; set wins over clear when both coincide.
REQ-015 SHALL treat timer_irq as level; no internal latch.
REQ-016 SHALL prioritise illegal_op > timer_irq > uart_pend, at most one take per cycle.
REQ-017 USER, illegal_op: exc_take=1, epc_we=1, epc=pc+4 (mod 2^32), cause=3, next KERNEL.
REQ-018 USER, no exception, request present and pc[31]==0: irq_take=1, epc_we=1, epc=pc (instruction squashed, re-executed on return), cause updated, next KERNEL.
REQ-019 USER with pc[31]==1 (boot/kernel code): no interrupt taken; requests remain pending.
REQ-020 KERNEL, illegal_op: exc_take=1, epc_we=0 ($k0 preserved), cause=3, stay KERNEL.
REQ-021 KERNEL, eret and no illegal_op: next SHADOW; requests arriving are held, never taken in KERNEL.
REQ-022 SHADOW: no interrupt taken (guarantees one user instruction per return); exception handled as USER; next USER.
REQ-023 All take/epc outputs SHALL be combinational in the same cycle as the trigger; state/cause/pending update at next edge (latency 0 to redirect, 1 to state).
REQ-024 eret in USER SHALL be ignored.

Reset
REQ-025 On reset_n==0 at clock edge: state USER, uart_pend 0, cause 0; reset overrides all simultaneous events.
REQ-026 While in reset, irq_take, exc_take, epc_we SHALL be 0, vector 0, epc 0, in_kernel 0.
REQ-027 Reset mid-handler SHALL discard KERNEL state without epc write.

Configuration
REQ-028 With UART_IRQ_EN defined, uart_irq is latched and arbitrated per REQ-014/016.
REQ-029 Without UART_IRQ_EN, uart_irq SHALL be ignored, uart_pend removed, cause never 2.

Structure
REQ-030 Shared package SHALL hold state encoding, cause codes, and constants IRQ_VECTOR=0x80000004, EXC_VECTOR=0x80000008.
REQ-031 Priority selection SHALL be a sub-module irq_prio_enc (combinational, 3 requests in, grant + cause out).

Verification
REQ-032 pc=0x0000006C, timer_irq=1 in USER -> irq_take=1, vector=0x80000004, epc=0x0000006C, next cycle in_kernel=1, cause=1.
REQ-033 uart_irq pulse while KERNEL, then eret -> SHADOW one cycle with no take, following USER cycle irq_take=1, cause=2.
REQ-034 illegal_op and timer_irq same USER cycle at pc=0x00000040 -> exc_take=1, vector=0x80000008, epc=0x00000044, timer still pending after return.
REQ-035 illegal_op in KERNEL -> exc_take=1, epc_we=0, in_kernel stays 1.
REQ-036 pc=0x80000050, timer_irq=1 in USER -> no take; pc=0x00000050 next -> irq_take=1.
REQ-037 reset_n=0 during KERNEL with uart pending -> next cycle USER, pending cleared, all take outputs 0.
